// File: rtl/graycodecounter_pkg.sv
// Shared types and default widths for the Gray-sequence decoder.
package graycodecounter_pkg;

    localparam int GRAY_W_DEF = 3;
    localparam int ERR_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } gray_state_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion, MSB first running XOR.
module gray2bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    logic acc;

    always_comb begin
        bin_o = '0;
        acc   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_seq_decoder.sv
// Decodes a Gray-coded count, tracks step direction and lock, and counts illegal jumps.
// Handshake: a sample is consumed on every rising edge where in_valid=1 (no backpressure).
module gray_seq_decoder
    import graycodecounter_pkg::*;
#(
    parameter int W    = GRAY_W_DEF,
    parameter int ERRW = ERR_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [W-1:0]    gray_in,
    output logic [W-1:0]    bin_out,
    output logic            bin_valid,
    output logic            dir_up,
    output logic            locked,
    output logic            step_err,
    output logic [ERRW-1:0] err_count,
    output gray_state_e     state_dbg
);

    localparam logic [W-1:0]    ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ONE_ERRW = {{(ERRW-1){1'b0}}, 1'b1};

    gray_state_e     state_q, state_d;
    logic [W-1:0]    ref_gray_q, ref_gray_d;
    logic [W-1:0]    ref_bin_q, ref_bin_d;
    logic [W-1:0]    bin_out_q, bin_out_d;
    logic            bin_valid_q, bin_valid_d;
    logic            dir_up_q, dir_up_d;
    logic            locked_q, locked_d;
    logic            step_err_q, step_err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;

    logic [W-1:0] bin_new;
    logic [W-1:0] diff;
    logic [W-1:0] delta;
    logic         dist_zero;
    logic         dist_one;
    logic         step_up;
    logic         step_dn;

    gray2bin #(.W(W)) u_gray2bin (
        .gray_i (gray_in),
        .bin_o  (bin_new)
    );

    // Distance 1 is a single set bit: nonzero and clearing the lowest bit leaves zero.
    always_comb begin
        diff      = gray_in ^ ref_gray_q;
        dist_zero = (diff == '0);
        dist_one  = !dist_zero && ((diff & (diff - ONE_W)) == '0);
        delta     = bin_new - ref_bin_q;
        step_up   = (delta == ONE_W);
        step_dn   = (delta == '1);
    end

    always_comb begin
        state_d     = state_q;
        ref_gray_d  = ref_gray_q;
        ref_bin_d   = ref_bin_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        dir_up_d    = dir_up_q;
        step_err_d  = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            ref_gray_d  = gray_in;
            ref_bin_d   = bin_new;
            bin_out_d   = bin_new;
            bin_valid_d = 1'b1;
            unique case (state_q)
                ST_UNLOCKED: state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (dist_one) begin
                        state_d = ST_LOCKED;
                        if (step_up)      dir_up_d = 1'b1;
                        else if (step_dn) dir_up_d = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (dist_one) begin
                        if (step_up)      dir_up_d = 1'b1;
                        else if (step_dn) dir_up_d = 1'b0;
                    end else if (!dist_zero) begin
                        step_err_d = 1'b1;
                        state_d    = ST_ACQUIRE;
                        if (err_count_q != '1) err_count_d = err_count_q + ONE_ERRW;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            ref_gray_q  <= '0;
            ref_bin_q   <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
            locked_q    <= 1'b0;
            step_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ref_gray_q  <= ref_gray_d;
            ref_bin_q   <= ref_bin_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            dir_up_q    <= dir_up_d;
            locked_q    <= locked_d;
            step_err_q  <= step_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign dir_up    = dir_up_q;
    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Directed and randomized checks of gray_seq_decoder against a behavioural scoreboard.
module tb_gray_seq_decoder;
    import graycodecounter_pkg::*;

    localparam int W    = 3;
    localparam int ERRW = 8;
    localparam int EW   = W + ERRW + 6;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [W-1:0]    gray_in;
    logic [W-1:0]    bin_out;
    logic            bin_valid;
    logic            dir_up;
    logic            locked;
    logic            step_err;
    logic [ERRW-1:0] err_count;
    gray_state_e     state_dbg;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    logic [1:0]      m_state;
    logic [W-1:0]    m_rg, m_rb, m_bin;
    logic            m_dir;
    logic [ERRW-1:0] m_cnt;

    gray_seq_decoder #(.W(W), .ERRW(ERRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .dir_up    (dir_up),
        .locked    (locked),
        .step_err  (step_err),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_rg    = '0;
        m_rb    = '0;
        m_bin   = '0;
        m_dir   = 1'b0;
        m_cnt   = '0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic v, input logic [W-1:0] g);
        logic [W-1:0] nb, d;
        int           hd;
        logic         bv, se;
        bv = 1'b0;
        se = 1'b0;
        if (v) begin
            nb = to_bin(g);
            hd = $countones(g ^ m_rg);
            d  = nb - m_rb;
            case (m_state)
                2'd0: m_state = 2'd1;
                2'd1: if (hd == 1) begin
                    m_state = 2'd2;
                    if (d == 1) m_dir = 1'b1;
                    else if (d == '1) m_dir = 1'b0;
                end
                default: if (hd == 1) begin
                    if (d == 1) m_dir = 1'b1;
                    else if (d == '1) m_dir = 1'b0;
                end else if (hd > 1) begin
                    se = 1'b1;
                    m_state = 2'd1;
                    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                end
            endcase
            m_rg  = g;
            m_rb  = nb;
            m_bin = nb;
            bv    = 1'b1;
        end
        exp_q.push_back({m_bin, bv, m_dir, (m_state == 2'd2), se, m_cnt, m_state});
    endtask

    task automatic check_out();
        logic [EW-1:0] e;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL sb_empty: observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bin_out",   32'(bin_out),   32'(e[EW-1 -: W]));
            chk("bin_valid", 32'(bin_valid), 32'(e[ERRW+5]));
            chk("dir_up",    32'(dir_up),    32'(e[ERRW+4]));
            chk("locked",    32'(locked),    32'(e[ERRW+3]));
            chk("step_err",  32'(step_err),  32'(e[ERRW+2]));
            chk("err_count", 32'(err_count), 32'(e[ERRW+1:2]));
            chk("state",     32'(state_dbg), 32'(e[1:0]));
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] g);
        @(negedge clk);
        in_valid = v;
        gray_in  = g;
        model_push(v, g);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic release_step(input logic [W-1:0] g);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        gray_in  = g;
        model_push(1'b1, g);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"},    32'(bin_out),   0);
        chk({tag, "_valid"},  32'(bin_valid), 0);
        chk({tag, "_dir"},    32'(dir_up),    0);
        chk({tag, "_locked"}, 32'(locked),    0);
        chk({tag, "_err"},    32'(step_err),  0);
        chk({tag, "_cnt"},    32'(err_count), 0);
        chk({tag, "_state"},  32'(state_dbg), 32'(ST_UNLOCKED));
    endtask

    task automatic error_cycle();
        logic [W-1:0] a, b, c;
        a = W'($urandom_range(0, (1 << W) - 1));
        b = a + 1'b1;
        c = b + 2'd2;
        for (int k = 0; k < 8; k++) begin
            c = W'($urandom_range(0, (1 << W) - 1));
            if ($countones(to_gray(c) ^ to_gray(b)) > 1) break;
            c = b + 2'd2;
        end
        step(1'b1, to_gray(a));
        step(1'b1, to_gray(b));
        step(1'b1, to_gray(c));
    endtask

    initial begin
        logic [W-1:0] sweep[9];
        sweep = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        reset    = 1'b1;
        in_valid = 1'b0;
        gray_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");

        // Up sweep with wrap, first sample on the first edge after release.
        release_step(sweep[0]);
        chk("sweep_bin0", 32'(bin_out), 0);
        for (int i = 1; i < 9; i++) begin
            step(1'b1, sweep[i]);
            chk("sweep_bin",    32'(bin_out),  32'(i % 8));
            chk("sweep_locked", 32'(locked),   1);
            chk("sweep_dir",    32'(dir_up),   1);
            chk("sweep_err",    32'(step_err), 0);
        end
        step(1'b0, 3'b111);
        chk("idle_bin", 32'(bin_out), 0);

        // Down steps including 0 -> 7 wrap.
        step(1'b1, 3'b100);
        chk("down_bin7", 32'(bin_out), 7);
        step(1'b1, 3'b101);
        chk("down_bin6", 32'(bin_out), 6);
        step(1'b1, 3'b111);
        chk("down_bin5", 32'(bin_out), 5);
        chk("down_dir",  32'(dir_up),  0);
        chk("down_lock", 32'(locked),  1);

        // Illegal jump then re-lock.
        apply_reset();
        release_step(3'b000);
        step(1'b1, 3'b001);
        step(1'b1, 3'b111);
        chk("jump_err",    32'(step_err),  1);
        chk("jump_cnt",    32'(err_count), 1);
        chk("jump_locked", 32'(locked),    0);
        step(1'b1, 3'b101);
        chk("relock",     32'(locked), 1);
        chk("relock_dir", 32'(dir_up), 1);

        // Repeated samples while locked.
        apply_reset();
        release_step(3'b001);
        step(1'b1, 3'b011);
        step(1'b1, 3'b011);
        chk("rep1_valid", 32'(bin_valid), 1);
        step(1'b1, 3'b011);
        chk("rep2_valid", 32'(bin_valid), 1);
        chk("rep_bin",    32'(bin_out),   2);
        chk("rep_err",    32'(step_err),  0);
        chk("rep_dir",    32'(dir_up),    1);

        // Saturation of the error counter.
        apply_reset();
        release_step(3'b000);
        for (int n = 0; n < 300; n++) error_cycle();
        chk("sat_cnt", 32'(err_count), 255);
        chk("sat_err", 32'(step_err),  1);
        step(1'b0, 3'b000);

        // Asynchronous reset while locked with three errors logged.
        apply_reset();
        release_step(3'b000);
        for (int n = 0; n < 3; n++) error_cycle();
        step(1'b1, 3'b000);
        step(1'b1, 3'b001);
        step(1'b1, 3'b011);
        chk("pre_cnt",  32'(err_count), 3);
        chk("pre_lock", 32'(locked),    1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("async");
        release_step(3'b110);
        chk("post_state", 32'(state_dbg), 32'(ST_ACQUIRE));
        step(1'b0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
